stopwatch_datapath: RTL

//   Stopwatch time base and counter core. Divides the system clock down to a 100 Hz tick.

---
 rtl/stopwatch_datapath.sv | 139 +++++++++++++
 1 files changed

// File: rtl/stopwatch_datapath.sv
// Stopwatch time base and counter core: divides clk down to the centisecond
// tick, runs the STOP/RUN/CLEAR control FSM and keeps the cascaded
// centisecond/second/minute/hour counters that feed the display controller.
// DIV = CLK_FREQ/TICK_HZ must be at least 2.
module stopwatch_datapath #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int TICK_HZ  = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_runstop,
   input  logic        i_clear,
   output logic [23:0] o_time,
   output logic        o_running,
   output logic        o_tick
);

   localparam int DIV = CLK_FREQ / TICK_HZ;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] tick_cnt_q, tick_cnt_d;
   logic [6:0]    msec_q, msec_d;
   logic [5:0]    sec_q, sec_d;
   logic [5:0]    min_q, min_d;
   logic [4:0]    hour_q, hour_d;
   logic          tick_q, tick_d;
   logic          running_q, running_d;

   logic          enter_clear;
   logic          tick_fire;

   // A clear request is only taken from STOP; the tick only fires while running.
   assign enter_clear = (state_q == ST_STOP) && i_clear;
   assign tick_fire   = (state_q == ST_RUN) && (tick_cnt_q == TICK_LAST);

   // Control FSM next state; clear beats a simultaneous run/stop request in STOP.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_STOP: begin
            if (i_clear) begin
               state_d = ST_CLEAR;
            end else if (i_runstop) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_runstop) begin
               state_d = ST_STOP;
            end
         end
         ST_CLEAR: state_d = ST_STOP;
         default:  state_d = ST_STOP;
      endcase
   end

   // Tick divider: advances only in RUN, so the sub-tick phase survives a stop.
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      if (enter_clear) begin
         tick_cnt_d = '0;
      end else if (state_q == ST_RUN) begin
         tick_cnt_d = tick_fire ? '0 : tick_cnt_q + 1'b1;
      end
   end

   // Time counter cascade; every carry resolves within the tick edge.
   always_comb begin
      msec_d = msec_q;
      sec_d  = sec_q;
      min_d  = min_q;
      hour_d = hour_q;
      if (enter_clear) begin
         msec_d = '0;
         sec_d  = '0;
         min_d  = '0;
         hour_d = '0;
      end else if (tick_fire) begin
         if (msec_q == 7'd99) begin
            msec_d = '0;
            if (sec_q == 6'd59) begin
               sec_d = '0;
               if (min_q == 6'd59) begin
                  min_d  = '0;
                  hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end else begin
            msec_d = msec_q + 7'd1;
         end
      end
   end

   // Registered status outputs, aligned with the counter update they describe.
   always_comb begin
      tick_d    = tick_fire;
      running_d = (state_d == ST_RUN);
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_STOP;
         tick_cnt_q <= '0;
         msec_q     <= '0;
         sec_q      <= '0;
         min_q      <= '0;
         hour_q     <= '0;
         tick_q     <= 1'b0;
         running_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         msec_q     <= msec_d;
         sec_q      <= sec_d;
         min_q      <= min_d;
         hour_q     <= hour_d;
         tick_q     <= tick_d;
         running_q  <= running_d;
      end
   end

   assign o_time    = {hour_q, min_q, sec_q, msec_q};
   assign o_running = running_q;
   assign o_tick    = tick_q;

endmodule
